// File: rtl/range_arb_pkg.sv
// range_arb_pkg: shared sizing helpers and the stored-word type for range_arb_fifo.
//
//   rng_width(hi, lo) : number of bits in a bus declared [hi:lo] or [lo:hi]
//   idx_w(n)          : bits needed to name one of n lanes (never less than 1)
//   cnt_w(depth)      : bits needed to hold an occupancy of 0..depth
//   pair_word_t       : one stored {o0-side, o1-side} pair at the default bounds
package range_arb_pkg;

    function automatic int unsigned rng_width(input int hi, input int lo);
        return int'(hi - lo + 1);
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_HI = 2;
    localparam int DEF_LO = -2;

    // Upper half holds the o0-side bits and the lower half holds the o1-side bits.
    // Within each half, bit (k - LO) carries declared index k.
    typedef logic [2*rng_width(DEF_HI, DEF_LO)-1:0] pair_word_t;

endpackage

// File: rtl/range_fifo.sv
// range_fifo: single-lane synchronous FIFO used by range_arb_fifo.
//
// Parameters: WIDTH (word width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   push       : write push_data this cycle (ignored while full)
//   push_data  : word to store
//   pop        : drop the head entry this cycle (ignored while empty)
//   head       : oldest stored word
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module range_fifo
    import range_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned AW = CW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset; clearing the pointers and count is enough to discard it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so incrementing them wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/range_arb_fifo.sv
// range_arb_fifo: per-lane FIFOs for mixed-direction range buses, merged by a
// round-robin arbiter into one registered valid/ready output.
//
// Parameters: HI, LO (bus index bounds, LO may be negative), CHANNELS (1..16),
//             DEPTH (entries per lane, power of two), SWAP (exchange i0/i1 roles).
// Ports:
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  : per-lane handshake
//   i0 [c][HI:LO]      : descending input word of lane c
//   i1 [c][LO:HI]      : ascending input word of lane c
//   out_valid/out_ready: output handshake
//   o0 [HI:LO], o1 [LO:HI] : output words, mapped by declared index
//   o_chan             : lane that produced the current output word
//   level              : per-lane FIFO count (only with RANGE_ARB_LEVEL_EN)
//
// Optional feature macro: RANGE_ARB_LEVEL_EN adds the level port.
module range_arb_fifo
    import range_arb_pkg::*;
#(
    parameter int          HI       = 2,
    parameter int          LO       = -2,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 4,
    parameter bit          SWAP     = 1'b0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNELS-1:0]                 in_valid,
    output logic [CHANNELS-1:0]                 in_ready,
    input  logic [CHANNELS-1:0][HI:LO]          i0,
    input  logic [CHANNELS-1:0][LO:HI]          i1,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [HI:LO]                        o0,
    output logic [LO:HI]                        o1,
    output logic [idx_w(CHANNELS)-1:0]          o_chan
`ifdef RANGE_ARB_LEVEL_EN
    ,
    output logic [CHANNELS-1:0][cnt_w(DEPTH)-1:0] level
`endif
);

    localparam int unsigned W  = rng_width(HI, LO);
    localparam int unsigned IW = idx_w(CHANNELS);
    localparam int unsigned CW = cnt_w(DEPTH);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    typedef logic [2*W-1:0] word_t;

    logic [0:0]                 state;
    logic [CHANNELS-1:0]        lane_full;
    logic [CHANNELS-1:0]        lane_empty;
    logic [CHANNELS-1:0]        nonempty;
    logic [CHANNELS-1:0]        push;
    logic [CHANNELS-1:0]        pop;
    logic [CHANNELS-1:0][CW-1:0] lane_count;
    word_t                      heads [CHANNELS];
    word_t                      sel_word;
    logic [IW-1:0]              rr_ptr;
    logic [IW-1:0]              grant;
    logic                       found;
    logic                       load;
    logic [HI:LO]               o0_next;
    logic [LO:HI]               o1_next;

    assign in_ready = ~lane_full & {CHANNELS{~rst}};
    assign push     = in_valid & in_ready;
    assign nonempty = ~lane_empty;

    // Each lane packs its pair into one word. Bit (k - LO) of each half holds
    // declared index k, so the bit mapping is the same for either bus direction.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        word_t wr_word;

        for (genvar j = 0; j < W; j++) begin : g_bit
            if (SWAP) begin : g_swap
                assign wr_word[W+j] = i1[c][LO+j];
                assign wr_word[j]   = i0[c][LO+j];
            end else begin : g_keep
                assign wr_word[W+j] = i0[c][LO+j];
                assign wr_word[j]   = i1[c][LO+j];
            end
        end

        assign pop[c] = load && (grant == IW'(c));

        range_fifo #(
            .WIDTH (2*W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[c]),
            .push_data (wr_word),
            .pop       (pop[c]),
            .head      (heads[c]),
            .full      (lane_full[c]),
            .empty     (lane_empty[c]),
            .count     (lane_count[c])
        );
    end

`ifdef RANGE_ARB_LEVEL_EN
    assign level = lane_count;
`else
    logic unused_count;
    assign unused_count = ^lane_count;
`endif

    // The cyclic search is done in two linear passes. The first pass looks at
    // lanes at or above rr_ptr. The second pass takes the lowest non-empty lane,
    // which can only win when every lane at or above rr_ptr is empty.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!found && nonempty[c] && (c >= 32'(rr_ptr))) begin
                found = 1'b1;
                grant = IW'(c);
            end
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!found && nonempty[c]) begin
                found = 1'b1;
                grant = IW'(c);
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (grant == IW'(c)) begin
                sel_word = heads[c];
            end
        end
    end

    for (genvar j = 0; j < W; j++) begin : g_unpack
        assign o0_next[LO+j] = sel_word[W+j];
        assign o1_next[LO+j] = sel_word[j];
    end

    assign out_valid = (state == ST_FULL);
    assign load      = (!out_valid || out_ready) && found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            o0     <= '0;
            o1     <= '0;
            o_chan <= '0;
            rr_ptr <= '0;
        end else begin
            if (load) begin
                state  <= ST_FULL;
                o0     <= o0_next;
                o1     <= o1_next;
                o_chan <= grant;
                rr_ptr <= (32'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
            end else if (state == ST_FULL && out_ready) begin
                state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_range_arb_fifo.sv
module tb_range_arb_fifo;
    import range_arb_pkg::*;

    logic             clk;
    logic             rst;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0]       in_ready_s;
    logic [1:0][2:-2] i0;
    logic [1:0][-2:2] i1;
    logic             out_valid;
    logic             out_valid_s;
    logic             out_ready;
    logic [2:-2]      o0;
    logic [2:-2]      o0_s;
    logic [-2:2]      o1;
    logic [-2:2]      o1_s;
    logic [0:0]       o_chan;
    logic [0:0]       o_chan_s;
`ifdef RANGE_ARB_LEVEL_EN
    logic [1:0][2:0]  level;
    logic [1:0][2:0]  level_s;
`endif

    pair_word_t q0[$];
    pair_word_t q1[$];
    logic [1:0] acc;
    int         checks   = 0;
    int         failures = 0;

    range_arb_fifo #(
        .HI(2), .LO(-2), .CHANNELS(2), .DEPTH(4), .SWAP(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .i0(i0), .i1(i1), .out_valid(out_valid), .out_ready(out_ready),
        .o0(o0), .o1(o1), .o_chan(o_chan)
`ifdef RANGE_ARB_LEVEL_EN
        , .level(level)
`endif
    );

    range_arb_fifo #(
        .HI(2), .LO(-2), .CHANNELS(2), .DEPTH(4), .SWAP(1'b1)
    ) dut_swap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .i0(i0), .i1(i1), .out_valid(out_valid_s), .out_ready(out_ready),
        .o0(o0_s), .o1(o1_s), .o_chan(o_chan_s)
`ifdef RANGE_ARB_LEVEL_EN
        , .level(level_s)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Settle the inputs, record the handshakes that the next edge will take,
    // then advance to just after that edge.
    task automatic step();
        pair_word_t w;
        #1;
        acc = in_valid & in_ready;
        for (int c = 0; c < 2; c++) begin
            if (acc[c]) begin
                w = {i0[c], i1[c]};
                if (c == 0) q0.push_back(w);
                else        q1.push_back(w);
            end
        end
        if (out_valid && out_ready) begin
            if (o_chan == 1'b0) begin
                chk("sb_pending_lane0", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    w = q0.pop_front();
                    chk("sb_o0_lane0", 32'(o0), 32'(w[9:5]));
                    chk("sb_o1_lane0", 32'(o1), 32'(w[4:0]));
                end
            end else begin
                chk("sb_pending_lane1", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    w = q1.pop_front();
                    chk("sb_o0_lane1", 32'(o0), 32'(w[9:5]));
                    chk("sb_o1_lane1", 32'(o1), 32'(w[4:0]));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        in_valid  = 2'b00;
        out_ready = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0 || out_valid) && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(q0.size() + q1.size()), 32'd0);
        chk({tag, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic got6;

        // Reset held two cycles with both lanes requesting.
        rst       = 1'b1;
        in_valid  = 2'b11;
        out_ready = 1'b1;
        i0        = '0;
        i1        = '0;
        step();
        chk("rst_in_ready_1", 32'(in_ready), 32'd0);
        chk("rst_out_valid_1", 32'(out_valid), 32'd0);
        step();
        chk("rst_in_ready_2", 32'(in_ready), 32'd0);
        chk("rst_out_valid_2", 32'(out_valid), 32'd0);
        rst      = 1'b0;
        in_valid = 2'b00;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd3);
        chk("post_rst_o0", 32'(o0), 32'd0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        step();

        // Single word on lane 0, checked by declared index on both builds.
        i0[0]    = 5'b10110;
        i1[0]    = 5'b10000;
        in_valid = 2'b01;
        step();
        in_valid = 2'b00;
        step();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_chan", 32'(o_chan), 32'd0);
        chk("single_o0_hi", 32'(o0[2]), 32'd1);
        chk("single_o0_lo", 32'(o0[-2]), 32'd0);
        chk("single_o1_lo", 32'(o1[-2]), 32'd1);
        chk("single_o1_hi", 32'(o1[2]), 32'd0);
        chk("swap_valid", 32'(out_valid_s), 32'd1);
        chk("swap_o0", 32'(o0_s), 32'b00001);
        for (int k = -2; k <= 2; k++) begin
            chk("swap_o1_bit", 32'(o1_s[k]), 32'(i0[0][k]));
        end
        step();
        drain("single_drain");

        // Lane 1 fills its FIFO and the output register while stalled.
        out_ready = 1'b0;
        in_valid  = 2'b10;
        for (int w = 0; w < 5; w++) begin
            i0[1] = 5'(w);
            i1[1] = 5'(~w);
            step();
            chk("bp_accept", 32'(acc[1]), 32'd1);
        end
        chk("bp_full_ready", 32'(in_ready[1]), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_chan", 32'(o_chan), 32'd1);
        i0[1] = 5'd5;
        i1[1] = 5'(~5);
        step();
        chk("bp_sixth_blocked", 32'(acc[1]), 32'd0);
        step();
        chk("bp_sixth_blocked_2", 32'(acc[1]), 32'd0);
        out_ready = 1'b1;
        got6      = 1'b0;
        for (int w = 0; w < 5; w++) begin
            chk("bp_drain_valid", 32'(out_valid), 32'd1);
            step();
            if (acc[1]) begin
                got6     = 1'b1;
                in_valid = 2'b00;
            end
        end
        chk("bp_sixth_accepted", 32'(got6), 32'd1);
        drain("bp_drain");

        // Fairness from a freshly reset pointer.
        rst = 1'b1;
        step();
        rst       = 1'b0;
        in_valid  = 2'b11;
        out_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            i0[0] = 5'($urandom); i1[0] = 5'($urandom);
            i0[1] = 5'($urandom); i1[1] = 5'($urandom);
            step();
        end
        for (int s = 0; s < 8; s++) begin
            chk("fair_valid", 32'(out_valid), 32'd1);
            chk("fair_chan", 32'(o_chan), 32'(s % 2));
            i0[0] = 5'($urandom); i1[0] = 5'($urandom);
            i0[1] = 5'($urandom); i1[1] = 5'($urandom);
            step();
        end
        drain("fair_drain");

        // Reset with one word presented and three queued on lane 0.
        out_ready = 1'b0;
        in_valid  = 2'b01;
        for (int s = 0; s < 4; s++) begin
            i0[0] = 5'($urandom);
            i1[0] = 5'($urandom);
            step();
        end
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        in_valid = 2'b00;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            chk("mid_no_stale", 32'(out_valid), 32'd0);
            step();
        end
        chk("mid_in_ready", 32'(in_ready), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
